// File: rtl/fft_line_sequencer.sv
// Streams NUM_LINES grid lines of N samples through a streaming FFT core:
// reads memory into a 2-entry skid FIFO feeding the FFT sink, and writes FFT source beats back.
module fft_line_sequencer #(
  parameter int DATA_W    = 32,
  parameter int LOG2_PTS  = 5,
  parameter int NUM_LINES = 1024,
  parameter int ADDR_W    = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   rd_real,
  input  logic [DATA_W-1:0]   rd_imag,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_real,
  output logic [DATA_W-1:0]   wr_imag,
  output logic                fft_sink_valid,
  input  logic                fft_sink_ready,
  output logic                fft_sink_sop,
  output logic                fft_sink_eop,
  output logic [1:0]          fft_sink_error,
  output logic [DATA_W-1:0]   fft_sink_real,
  output logic [DATA_W-1:0]   fft_sink_imag,
  output logic [LOG2_PTS:0]   fft_fftpts_in,
  input  logic                fft_source_valid,
  output logic                fft_source_ready,
  input  logic                fft_source_sop,
  input  logic                fft_source_eop,
  input  logic [1:0]          fft_source_error,
  input  logic [DATA_W-1:0]   fft_source_real,
  input  logic [DATA_W-1:0]   fft_source_imag,
  input  logic [LOG2_PTS:0]   fft_fftpts_out,
  output logic [1:0]          dbg_state
);

  localparam int N     = 1 << LOG2_PTS;
  localparam int TOTAL = NUM_LINES * N;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(TOTAL - 1);
  localparam logic [LOG2_PTS:0] PTS      = (LOG2_PTS + 1)'(N);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]    wr_idx_q, wr_idx_d;
  logic [LOG2_PTS-1:0] sink_idx_q, sink_idx_d;
  logic                rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0]   fifo_real_q [2];
  logic [DATA_W-1:0]   fifo_real_d [2];
  logic [DATA_W-1:0]   fifo_imag_q [2];
  logic [DATA_W-1:0]   fifo_imag_d [2];
  logic                fifo_wptr_q, fifo_wptr_d;
  logic                fifo_rptr_q, fifo_rptr_d;
  logic [1:0]          fifo_cnt_q, fifo_cnt_d;
  logic                err_q, err_d;
  logic                wr_en_q, wr_en_d;
  logic                wr_last_q, wr_last_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_real_q, wr_real_d;
  logic [DATA_W-1:0]   wr_imag_q, wr_imag_d;

  logic       start_ok, sink_fire, src_fire, src_bad, src_overrun;
  logic [2:0] occ_after;

  // Handshake rule on both FFT ports: a beat transfers on a rising edge where valid && ready;
  // the sender holds its payload unchanged until that edge.
  assign start_ok       = start && (state_q == S_IDLE);
  assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign err            = err_q;
  assign dbg_state      = state_q;
  assign fft_sink_valid = (fifo_cnt_q != 2'd0);
  assign sink_fire      = fft_sink_valid && fft_sink_ready;
  assign src_fire       = fft_source_valid && busy;

  // Occupancy counts the slot freed by this cycle's pop so the feeder can sustain 1 sample/cycle.
  assign occ_after = {1'b0, fifo_cnt_q} - {2'b00, sink_fire} + {2'b00, rd_pend_q};
  assign rd_en     = (state_q == S_RUN) && (occ_after < 3'd2);
  assign rd_addr   = rd_idx_q[ADDR_W-1:0];

  assign fft_sink_sop     = fft_sink_valid && (sink_idx_q == '0);
  assign fft_sink_eop     = fft_sink_valid && (sink_idx_q == {LOG2_PTS{1'b1}});
  assign fft_sink_error   = 2'b00;
  assign fft_sink_real    = fifo_real_q[fifo_rptr_q];
  assign fft_sink_imag    = fifo_imag_q[fifo_rptr_q];
  assign fft_fftpts_in    = busy ? PTS : '0;
  assign fft_source_ready = busy;

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_real = wr_real_q;
  assign wr_imag = wr_imag_q;

  assign src_overrun = (wr_idx_q > LAST_IDX);
  assign src_bad = (fft_source_sop != (wr_idx_q[LOG2_PTS-1:0] == '0)) ||
                   (fft_source_eop != (wr_idx_q[LOG2_PTS-1:0] == {LOG2_PTS{1'b1}})) ||
                   (fft_source_error != 2'b00) ||
                   (fft_source_sop && (fft_fftpts_out != PTS)) ||
                   src_overrun;

  always_comb begin
    state_d     = state_q;
    rd_idx_d    = rd_idx_q;
    wr_idx_d    = wr_idx_q;
    sink_idx_d  = sink_idx_q;
    rd_pend_d   = rd_en;
    fifo_real_d = fifo_real_q;
    fifo_imag_d = fifo_imag_q;
    fifo_wptr_d = fifo_wptr_q;
    fifo_rptr_d = fifo_rptr_q;
    fifo_cnt_d  = fifo_cnt_q + {1'b0, rd_pend_q} - {1'b0, sink_fire};
    err_d       = err_q;
    wr_en_d     = src_fire && !src_overrun;
    wr_last_d   = src_fire && (wr_idx_q == LAST_IDX);
    wr_addr_d   = wr_addr_q;
    wr_real_d   = wr_real_q;
    wr_imag_d   = wr_imag_q;

    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN:   if (rd_en && (rd_idx_q == LAST_IDX)) state_d = S_DRAIN;
      S_DRAIN: if (wr_en_q && wr_last_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (rd_pend_q) begin
      fifo_real_d[fifo_wptr_q] = rd_real;
      fifo_imag_d[fifo_wptr_q] = rd_imag;
      fifo_wptr_d = ~fifo_wptr_q;
    end
    if (sink_fire) begin
      fifo_rptr_d = ~fifo_rptr_q;
      sink_idx_d  = sink_idx_q + 1'b1;
    end
    if (rd_en) rd_idx_d = rd_idx_q + 1'b1;

    if (src_fire) begin
      wr_idx_d  = wr_idx_q + 1'b1;
      wr_addr_d = wr_idx_q[ADDR_W-1:0];
      wr_real_d = fft_source_real;
      wr_imag_d = fft_source_imag;
      if (src_bad) err_d = 1'b1;
    end

    if (start_ok) begin
      rd_idx_d   = '0;
      wr_idx_d   = '0;
      sink_idx_d = '0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rd_idx_q    <= '0;
      wr_idx_q    <= '0;
      sink_idx_q  <= '0;
      rd_pend_q   <= 1'b0;
      fifo_real_q <= '{default: '0};
      fifo_imag_q <= '{default: '0};
      fifo_wptr_q <= 1'b0;
      fifo_rptr_q <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      err_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_last_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_real_q   <= '0;
      wr_imag_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_idx_q    <= rd_idx_d;
      wr_idx_q    <= wr_idx_d;
      sink_idx_q  <= sink_idx_d;
      rd_pend_q   <= rd_pend_d;
      fifo_real_q <= fifo_real_d;
      fifo_imag_q <= fifo_imag_d;
      fifo_wptr_q <= fifo_wptr_d;
      fifo_rptr_q <= fifo_rptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      err_q       <= err_d;
      wr_en_q     <= wr_en_d;
      wr_last_q   <= wr_last_d;
      wr_addr_q   <= wr_addr_d;
      wr_real_q   <= wr_real_d;
      wr_imag_q   <= wr_imag_d;
    end
  end

endmodule

// File: tb/tb_fft_line_sequencer.sv
// Bench for fft_line_sequencer: 2 lines of 32 points, pattern memory, identity FFT with 10-cycle latency.
module tb_fft_line_sequencer;

  localparam int DATA_W = 32;
  localparam int LOG2_PTS = 5;
  localparam int NUM_LINES = 2;
  localparam int ADDR_W = 15;
  localparam int N = 32;
  localparam int TOTAL = NUM_LINES * N;
  localparam int LAT = 10;
  localparam int BUDGET = 3000;

  logic clk, reset_n, start;
  logic busy, done, err, rd_en, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] rd_real = '0, rd_imag = '0;
  logic [DATA_W-1:0] wr_real, wr_imag;
  logic fft_sink_valid, fft_sink_ready, fft_sink_sop, fft_sink_eop;
  logic [1:0] fft_sink_error;
  logic [DATA_W-1:0] fft_sink_real, fft_sink_imag;
  logic [LOG2_PTS:0] fft_fftpts_in, fft_fftpts_out;
  logic fft_source_valid, fft_source_ready, fft_source_sop, fft_source_eop;
  logic [1:0] fft_source_error;
  logic [DATA_W-1:0] fft_source_real, fft_source_imag;
  logic [1:0] dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int rand_ready = 0;
  int bad_sop_beat = -1;
  int bad_err_beat = -1;
  logic [ADDR_W+2*DATA_W-1:0] exp_q[$];

  fft_line_sequencer #(.DATA_W(DATA_W), .LOG2_PTS(LOG2_PTS), .NUM_LINES(NUM_LINES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_real(rd_real), .rd_imag(rd_imag),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_real(wr_real), .wr_imag(wr_imag),
    .fft_sink_valid(fft_sink_valid), .fft_sink_ready(fft_sink_ready),
    .fft_sink_sop(fft_sink_sop), .fft_sink_eop(fft_sink_eop), .fft_sink_error(fft_sink_error),
    .fft_sink_real(fft_sink_real), .fft_sink_imag(fft_sink_imag), .fft_fftpts_in(fft_fftpts_in),
    .fft_source_valid(fft_source_valid), .fft_source_ready(fft_source_ready),
    .fft_source_sop(fft_source_sop), .fft_source_eop(fft_source_eop),
    .fft_source_error(fft_source_error), .fft_source_real(fft_source_real),
    .fft_source_imag(fft_source_imag), .fft_fftpts_out(fft_fftpts_out), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] f_real(input logic [ADDR_W-1:0] a);
    return 32'h1357_9bdf ^ ({17'd0, a} * 32'h9e37_79b9);
  endfunction

  function automatic logic [DATA_W-1:0] f_imag(input logic [ADDR_W-1:0] a);
    return 32'hc0de_0000 + {17'd0, a};
  endfunction

  // Grid memory model: data one cycle after rd_en
  always @(posedge clk) begin
    if (rd_en) begin
      rd_real <= f_real(rd_addr);
      rd_imag <= f_imag(rd_addr);
    end
  end

  // Identity FFT model with fixed latency and optional framing/error faults
  logic pv [LAT];
  logic psop [LAT];
  logic peop [LAT];
  logic [DATA_W-1:0] pre [LAT];
  logic [DATA_W-1:0] pim [LAT];
  int src_cnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
      src_cnt <= 0;
    end else begin
      pv[0]   <= fft_sink_valid && fft_sink_ready;
      psop[0] <= fft_sink_sop;
      peop[0] <= fft_sink_eop;
      pre[0]  <= fft_sink_real;
      pim[0]  <= fft_sink_imag;
      for (int i = 1; i < LAT; i++) begin
        pv[i]   <= pv[i-1];
        psop[i] <= psop[i-1];
        peop[i] <= peop[i-1];
        pre[i]  <= pre[i-1];
        pim[i]  <= pim[i-1];
      end
      if (!fft_source_ready) src_cnt <= 0;
      else if (pv[LAT-1]) src_cnt <= src_cnt + 1;
    end
  end

  assign fft_source_valid = pv[LAT-1];
  assign fft_source_sop   = psop[LAT-1] | (pv[LAT-1] && (src_cnt == bad_sop_beat));
  assign fft_source_eop   = peop[LAT-1];
  assign fft_source_error = (pv[LAT-1] && (src_cnt == bad_err_beat)) ? 2'b01 : 2'b00;
  assign fft_source_real  = pre[LAT-1];
  assign fft_source_imag  = pim[LAT-1];
  assign fft_fftpts_out   = 6'd32;

  // Driver tasks
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic run_pass(input int abort_reads, input int start_pulse_cycle, input bit start_on_done,
                          input int err_addr, output int n_reads, output int n_sink, output int n_writes,
                          output int n_done, output int first_rd, output int first_valid,
                          output int last_wr, output int done_cycle, output logic err_first);
    logic [DATA_W*2+2:0] held;
    logic [DATA_W*2+1:0] sink_exp;
    logic [ADDR_W+2*DATA_W-1:0] wexp;
    bit hold, seen_done;
    int post;
    n_reads = 0; n_sink = 0; n_writes = 0; n_done = 0;
    first_rd = -1; first_valid = -1; last_wr = -1; done_cycle = -1; err_first = 1'bx;
    hold = 0; seen_done = 0; post = 0; held = '0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk);
      start = (cyc == start_pulse_cycle);
      fft_sink_ready = (rand_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cyc == 0) err_first = err;
      if (rd_en) begin
        vectors++;
        if (rd_addr !== ADDR_W'(n_reads)) begin
          miscompares++;
          $display("FAIL rd_order: rd_addr %0d expected %0d", rd_addr, n_reads);
        end
        exp_q.push_back({rd_addr, f_real(rd_addr), f_imag(rd_addr)});
        if (first_rd < 0) first_rd = cyc;
        n_reads++;
      end
      if (hold) begin
        vectors++;
        if ({fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_real, fft_sink_imag} !== held) begin
          miscompares++;
          $display("FAIL sink_stable: got %h held %h", {fft_sink_valid, fft_sink_sop, fft_sink_eop,
                   fft_sink_real, fft_sink_imag}, held);
        end
      end
      if (fft_sink_valid && first_valid < 0) first_valid = cyc;
      if (fft_sink_valid && fft_sink_ready) begin
        vectors++;
        sink_exp = {(n_sink % N) == 0, (n_sink % N) == N - 1, f_real(ADDR_W'(n_sink)), f_imag(ADDR_W'(n_sink))};
        if ({fft_sink_sop, fft_sink_eop, fft_sink_real, fft_sink_imag} !== sink_exp) begin
          miscompares++;
          $display("FAIL sink_beat %0d: got %h expected %h", n_sink,
                   {fft_sink_sop, fft_sink_eop, fft_sink_real, fft_sink_imag}, sink_exp);
        end
        n_sink++;
      end
      hold = fft_sink_valid && !fft_sink_ready;
      held = {fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_real, fft_sink_imag};
      vectors++;
      if (n_reads - n_sink > 2) begin
        miscompares++;
        $display("FAIL outstanding: %0d reads outstanding, limit 2", n_reads - n_sink);
      end
      if (busy) begin
        vectors++;
        if (fft_fftpts_in !== 6'd32) begin
          miscompares++;
          $display("FAIL fftpts_in: got %0d expected 32", fft_fftpts_in);
        end
      end
      if (wr_en) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: wr_addr %0d with empty expected queue", wr_addr);
        end else begin
          wexp = exp_q.pop_front();
          if ({wr_addr, wr_real, wr_imag} !== wexp) begin
            miscompares++;
            $display("FAIL wr_data: got %h expected %h", {wr_addr, wr_real, wr_imag}, wexp);
          end
        end
        if (err_addr < 0 || int'(wr_addr) < err_addr) begin
          vectors++;
          if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_early: err %b at wr_addr %0d expected 0", err, wr_addr);
          end
        end else if (int'(wr_addr) == err_addr) begin
          vectors++;
          if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_set: err %b at wr_addr %0d expected 1", err, wr_addr);
          end
        end
        last_wr = cyc;
        n_writes++;
      end
      if (done) begin
        n_done++;
        done_cycle = cyc;
        vectors++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
          miscompares++;
          $display("FAIL done_state: busy %b pending %0d expected busy 0 pending 0", busy, exp_q.size());
        end
        if (start_on_done) start = 1'b1;
      end
      if (abort_reads > 0 && n_reads >= abort_reads) begin
        reset_n = 1'b0;
        return;
      end
      if (seen_done) post++;
      if (done) seen_done = 1;
      if (post >= 4) break;
    end
    start = 1'b0;
    vectors++;
    if (!seen_done) begin
      miscompares++;
      $display("FAIL timeout: no done within %0d cycles (done seen 0, expected 1)", BUDGET);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({busy, done, err, rd_en, wr_en, fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_source_ready,
         dbg_state} !== '0 || {rd_addr, wr_addr, wr_real, wr_imag, fft_fftpts_in} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: ctl %b data %h expected all 0",
               {busy, done, err, rd_en, wr_en, fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_source_ready},
               {rd_addr, wr_addr, wr_real, wr_imag, fft_fftpts_in});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({busy, rd_en, fft_source_ready} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy/rd_en/ready %b expected 000", {busy, rd_en, fft_source_ready});
    end
  endtask

  task automatic test_basic();
    int nr, ns, nw, nd, fr, fv, lw, dc;
    logic ef;
    rand_ready = 0;
    do_start();
    run_pass(0, -1, 0, -1, nr, ns, nw, nd, fr, fv, lw, dc, ef);
    vectors++;
    if (nr != TOTAL || ns != TOTAL || nw != TOTAL || nd != 1) begin
      miscompares++;
      $display("FAIL basic_counts: reads %0d sink %0d writes %0d done %0d expected %0d/%0d/%0d/1",
               nr, ns, nw, nd, TOTAL, TOTAL, TOTAL);
    end
    vectors++;
    if (fr != 0 || fv != 2) begin
      miscompares++;
      $display("FAIL basic_latency: first rd_en cycle %0d first valid cycle %0d expected 0 and 2", fr, fv);
    end
    vectors++;
    if (dc != lw + 1) begin
      miscompares++;
      $display("FAIL done_timing: done cycle %0d expected %0d", dc, lw + 1);
    end
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_err: err %b expected 0", err);
    end
  endtask

  task automatic test_random_ready();
    int nr, ns, nw, nd, fr, fv, lw, dc;
    logic ef;
    rand_ready = 1;
    do_start();
    run_pass(0, -1, 0, -1, nr, ns, nw, nd, fr, fv, lw, dc, ef);
    rand_ready = 0;
    vectors++;
    if (nr != TOTAL || ns != TOTAL || nw != TOTAL || nd != 1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL random_ready: reads %0d sink %0d writes %0d done %0d err %b expected %0d each, 1, 0",
               nr, ns, nw, nd, err, TOTAL);
    end
  endtask

  task automatic test_bad_sop();
    int nr, ns, nw, nd, fr, fv, lw, dc;
    logic ef;
    bad_sop_beat = 5;
    do_start();
    run_pass(0, -1, 0, 5, nr, ns, nw, nd, fr, fv, lw, dc, ef);
    bad_sop_beat = -1;
    vectors++;
    if (nw != TOTAL || nd != 1 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_sop: writes %0d done %0d err %b expected %0d, 1, 1", nw, nd, err, TOTAL);
    end
  endtask

  task automatic test_clear_err();
    int nr, ns, nw, nd, fr, fv, lw, dc;
    logic ef;
    do_start();
    run_pass(0, -1, 0, -1, nr, ns, nw, nd, fr, fv, lw, dc, ef);
    vectors++;
    if (ef !== 1'b0 || err !== 1'b0 || nd != 1) begin
      miscompares++;
      $display("FAIL clear_err: err after start %b at end %b done %0d expected 0, 0, 1", ef, err, nd);
    end
  endtask

  task automatic test_start_ignored();
    int nr, ns, nw, nd, fr, fv, lw, dc;
    logic ef;
    do_start();
    run_pass(0, 20, 1, -1, nr, ns, nw, nd, fr, fv, lw, dc, ef);
    #1;
    vectors++;
    if (nr != TOTAL || nw != TOTAL || nd != 1 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL start_ignored: reads %0d writes %0d done %0d busy %b state %0d expected %0d, %0d, 1, 0, 0",
               nr, nw, nd, busy, dbg_state, TOTAL, TOTAL);
    end
  endtask

  task automatic test_reset_midpass();
    int nr, ns, nw, nd, fr, fv, lw, dc;
    logic ef;
    do_start();
    run_pass(40, -1, 0, -1, nr, ns, nw, nd, fr, fv, lw, dc, ef);
    #1;
    vectors++;
    if ({busy, done, err, rd_en, wr_en, fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_source_ready,
         dbg_state} !== '0 || {rd_addr, wr_addr, wr_real, wr_imag, fft_sink_real, fft_sink_imag,
         fft_fftpts_in} !== '0) begin
      miscompares++;
      $display("FAIL midpass_reset: ctl %b rd_addr %0d wr_addr %0d expected all 0",
               {busy, done, err, rd_en, wr_en, fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_source_ready},
               rd_addr, wr_addr);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    do_start();
    run_pass(0, -1, 0, -1, nr, ns, nw, nd, fr, fv, lw, dc, ef);
    vectors++;
    if (nr != TOTAL || ns != TOTAL || nw != TOTAL || nd != 1 || err !== 1'b0 || fr != 0) begin
      miscompares++;
      $display("FAIL after_reset_pass: reads %0d sink %0d writes %0d done %0d err %b first %0d expected %0d each, 1, 0, 0",
               nr, ns, nw, nd, err, fr, TOTAL);
    end
  endtask

  task automatic test_src_error_last();
    int nr, ns, nw, nd, fr, fv, lw, dc;
    logic ef;
    bad_err_beat = TOTAL - 1;
    do_start();
    run_pass(0, -1, 0, TOTAL - 1, nr, ns, nw, nd, fr, fv, lw, dc, ef);
    bad_err_beat = -1;
    vectors++;
    if (nw != TOTAL || nd != 1 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL src_error_last: writes %0d done %0d err %b expected %0d, 1, 1", nw, nd, err, TOTAL);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    fft_sink_ready = 1'b0;
    test_reset();
    test_basic();
    test_random_ready();
    test_bad_sop();
    test_clear_err();
    test_start_ignored();
    test_reset_midpass();
    test_src_error_last();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_line_sequencer.md
# fft_line_sequencer

Controller that streams a batch of grid lines through the fixed-size streaming FFT core. It issues reads of each line from the grid memory and presents them to the FFT sink with framing (sop/eop, point count). It accepts FFT source beats and writes them back to the grid memory, and reports completion and framing errors. It sits between the charge-grid memory and the FFT core, and is started once per 1-D FFT pass by the top-level long-range sequencer.

## Interface
- DATA_W, 32: real/imag sample width.
- LOG2_PTS, 5: log2 of FFT length N (N = 32).
- NUM_LINES, 1024: lines per pass.
- ADDR_W, 15: memory word address width; must be ≥ log2(NUM_LINES·N).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; ignored unless idle.
- busy  out  1  high from cycle after accepted start until done.
- done  out  1  one-cycle pulse at pass end.
- err  out  1  sticky framing/error flag, cleared by accepted start.
- rd_en  out  1; rd_addr  out  ADDR_W  memory read request.
- rd_real, rd_imag  in  DATA_W  read data, valid exactly 1 cycle after rd_en.
- wr_en  out  1; wr_addr  out  ADDR_W; wr_real, wr_imag  out  DATA_W  write port.
- fft_sink_valid  out  1; fft_sink_ready  in  1; fft_sink_sop, fft_sink_eop  out  1; fft_sink_error  out  2 (always 0); fft_sink_real, fft_sink_imag  out  DATA_W; fft_fftpts_in  out  LOG2_PTS+1.
- fft_source_valid  in  1; fft_source_ready  out  1; fft_source_sop, fft_source_eop  in  1; fft_source_error  in  2; fft_source_real, fft_source_imag  in  DATA_W; fft_fftpts_out  in  LOG2_PTS+1 (unused except check).

## Operation
- States: IDLE → RUN on start; RUN → DRAIN when the last read of line NUM_LINES-1 is issued; DRAIN → DONE when the last output beat of line NUM_LINES-1 is written; DONE → IDLE after one cycle (done=1 in DONE).
- Feeder: read counter rd_idx 0..NUM_LINES·N-1, rd_addr = rd_idx. Reads are in line order, natural sample order.
- rd_en is issued only when (skid FIFO occupancy + reads in flight) < 2. The 2-entry skid FIFO captures rd data and drives fft_sink_*.
- Sink framing: sop on sample index 0 of each line, eop on index N-1. Payload changes only after a valid&ready handshake. fft_fftpts_in = N constant while busy.
- Collector: fft_source_ready = 1 whenever busy. Each accepted beat writes wr_addr = wr_idx (wr_idx counts 0..NUM_LINES·N-1, natural order).
- Checks (each sets err, pass continues):
  - fft_source_sop ≠ (wr_idx mod N == 0)
  - fft_source_eop ≠ (wr_idx mod N == N-1)
  - fft_source_error ≠ 0
  - fft_fftpts_out ≠ N on sop
- Source beats arriving in IDLE are dropped (ready=0).
- Counters wrap nowhere; NUM_LINES·N beats each way exactly per pass.
- Reset mid-pass: all state, counters, FIFO and err return to reset values immediately. The FFT core is reset by the same reset_n.

## Timing
- Reset values: busy, done, err, rd_en, wr_en, fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_source_ready = 0. All addresses/data = 0. fft_fftpts_in = 0.
- start sampled at cycle t → busy=1 and first rd_en=1 at t+1.
- rd_en at t → FIFO write at end of t+1 → fft_sink_valid earliest t+2.
- Sustained throughput: 1 sample/cycle while fft_sink_ready=1.
- Accepted source beat at t → wr_en=1 with that data at t+1 (registered).
- done asserted the cycle after the final write's wr_en; busy drops in the same cycle done rises.
- start coincident with done or during busy is ignored.

## Test plan
- NUM_LINES=2, N=32, sink_ready=1, FFT model = identity with 10-cycle latency → 64 reads, 64 sink beats with sop at indices 0/32 and eop at 31/63, 64 writes wr_addr 0..63 matching data, done one pulse, err=0.
- Random fft_sink_ready (50%) → no sample lost or duplicated, sink payload stable while valid&!ready, never >2 reads outstanding.
- FFT model asserts source_sop on beat 5 of line 0 → err=1 by next cycle, pass still completes with done; next start clears err.
- start pulsed while busy, and again coincident with done → ignored; exactly one pass of writes.
- reset_n low mid-RUN (after 40 reads) → all outputs to reset values asynchronously; fresh start afterwards gives a clean full pass.
- source_error=2'b01 on the last beat → err=1, done still pulses.
